// File: rtl/gp_write_fifo.sv
// gp_write_fifo: GP write-back buffer. Packs 32-bit producer words into
// 8-word blocks held in a ping-pong 2x8 RAM and commits each block to DDR as
// one af write command plus two 128-bit wdf beats. Partially filled blocks are
// committed on flush with the unused words masked off.
module gp_write_fifo #(
  parameter int unsigned CNT_WIDTH = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [30:0]  base_addr,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  input  logic         flush,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic         af_wr_en,
  output logic [2:0]   af_cmd_din,
  output logic [30:0]  af_addr_din,
  output logic         wdf_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         busy,
  output logic [1:0]   state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CMD   = 2'd1;
  localparam logic [1:0] ST_BEAT2 = 2'd2;

  // Storage: block 0 = entries 0-7, block 1 = entries 8-15.
  logic [31:0]          r_mem [16];
  logic [3:0]           r_wr_ptr;
  logic                 r_rd_blk;
  logic [1:0]           r_blk_full;
  logic [3:0]           r_blk_cnt [2];
  logic [CNT_WIDTH-1:0] r_burst_cnt;
  logic [28:0]          r_base;
  logic [1:0]           r_state;

  logic       w_start;
  logic       w_accept;
  logic [3:0] w_ptr_after;
  logic       w_fill_done;
  logic       w_flush_do;
  logic       w_af_push;
  logic       w_beat2_push;

  logic [3:0]  w_wr_ptr_d;
  logic        w_rd_blk_d;
  logic [1:0]  w_blk_full_d;
  logic [3:0]  w_blk_cnt_d [2];
  logic [CNT_WIDTH-1:0] w_burst_cnt_d;
  logic [28:0] w_base_d;
  logic [1:0]  w_state_d;
  logic [28:0] w_burst_ext;

  // Address bits [1:0] are defined as ignored.
  logic w_unused;
  assign w_unused = ^base_addr[1:0];

  assign busy     = (|r_blk_full) | (r_state != ST_IDLE);
  assign w_start  = start & ~busy;
  assign in_ready = ~r_blk_full[r_wr_ptr[3]];
  assign w_accept = in_valid & in_ready;

  // Pointer after this cycle's accept; flush sizing is taken from it so a
  // simultaneous word is counted before the block is closed.
  assign w_ptr_after = w_accept ? (r_wr_ptr + 4'd1) : r_wr_ptr;
  assign w_fill_done = w_accept & (r_wr_ptr[2:0] == 3'd7);
  assign w_flush_do  = flush & (w_ptr_after[2:0] != 3'd0);

  // Both FIFOs must have room so the command and its first beat go together.
  assign w_af_push    = (r_state == ST_CMD) & ~af_full & ~wdf_full;
  assign w_beat2_push = (r_state == ST_BEAT2) & ~wdf_full;

  assign af_wr_en   = w_af_push;
  assign wdf_wr_en  = w_af_push | w_beat2_push;
  assign af_cmd_din = 3'b000;
  assign state      = r_state;

  assign w_burst_ext = 29'(r_burst_cnt);
  assign af_addr_din = {r_base + w_burst_ext, 2'b00};

  // Fill-side bookkeeping: write pointer and per-block full/count flags.
  always_comb begin
    w_wr_ptr_d     = w_ptr_after;
    w_blk_full_d   = r_blk_full;
    w_blk_cnt_d[0] = r_blk_cnt[0];
    w_blk_cnt_d[1] = r_blk_cnt[1];
    if (w_start) begin
      // Nothing is pending when start is honoured; any partial fill is dropped.
      w_wr_ptr_d = 4'd0;
    end else begin
      // The draining block is full, so the fill side never touches it here.
      if (w_beat2_push) begin
        w_blk_full_d[r_rd_blk] = 1'b0;
      end
      if (w_fill_done) begin
        w_blk_full_d[r_wr_ptr[3]] = 1'b1;
        w_blk_cnt_d[r_wr_ptr[3]]  = 4'd8;
      end
      if (w_flush_do) begin
        w_blk_full_d[w_ptr_after[3]] = 1'b1;
        w_blk_cnt_d[w_ptr_after[3]]  = {1'b0, w_ptr_after[2:0]};
        w_wr_ptr_d                   = {~w_ptr_after[3], 3'b000};
      end
    end
  end

  // Read-side bookkeeping: block selector, burst counter and latched base.
  always_comb begin
    w_rd_blk_d    = r_rd_blk;
    w_burst_cnt_d = r_burst_cnt;
    w_base_d      = r_base;
    if (w_start) begin
      w_rd_blk_d    = 1'b0;
      w_burst_cnt_d = '0;
      w_base_d      = base_addr[30:2];
    end else begin
      if (w_beat2_push) begin
        w_rd_blk_d = ~r_rd_blk;
      end
      if (w_af_push) begin
        w_burst_cnt_d = r_burst_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Drain FSM next state.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_IDLE:  if (r_blk_full[r_rd_blk]) w_state_d = ST_CMD;
      ST_CMD:   if (w_af_push) w_state_d = ST_BEAT2;
      ST_BEAT2: if (w_beat2_push) w_state_d = ST_IDLE;
      default:  w_state_d = ST_IDLE;
    endcase
  end

  // Beat assembly: BEAT2 selects words 4-7 of the draining block, otherwise
  // words 0-3, so data and mask hold steady while a push is stalled.
  always_comb begin
    logic       w_hi;
    logic [2:0] w_word;
    logic [3:0] w_idx;
    w_hi         = (r_state == ST_BEAT2);
    w_word       = 3'd0;
    w_idx        = 4'd0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    for (int j = 0; j < 4; j++) begin
      w_word = {w_hi, 2'(j)};
      w_idx  = {r_rd_blk, w_word};
      wdf_din[32*j +: 32] = r_mem[w_idx];
      if ({1'b0, w_word} >= r_blk_cnt[r_rd_blk]) begin
        wdf_mask_din[4*j +: 4] = 4'hF;
      end
    end
  end

  // Word RAM write port; the RAM itself carries no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= 4'd0;
      r_rd_blk     <= 1'b0;
      r_blk_full   <= 2'b00;
      r_blk_cnt[0] <= 4'd0;
      r_blk_cnt[1] <= 4'd0;
      r_burst_cnt  <= '0;
      r_base       <= 29'd0;
      r_state      <= ST_IDLE;
    end else begin
      r_wr_ptr     <= w_wr_ptr_d;
      r_rd_blk     <= w_rd_blk_d;
      r_blk_full   <= w_blk_full_d;
      r_blk_cnt[0] <= w_blk_cnt_d[0];
      r_blk_cnt[1] <= w_blk_cnt_d[1];
      r_burst_cnt  <= w_burst_cnt_d;
      r_base       <= w_base_d;
      r_state      <= w_state_d;
    end
  end

endmodule

// File: tb/tb_gp_write_fifo.sv
// Bench for gp_write_fifo: a table of block sizes checks burst address, data,
// masks and latency; hand sequences cover backpressure, start-while-busy,
// reset mid-burst and burst counter wrap (second instance, CNT_WIDTH=2).
module tb_gp_write_fifo;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, flush, af_full, wdf_full;
  logic [30:0]  base_addr;
  logic [31:0]  in_data;
  logic         in_ready, af_wr_en, wdf_wr_en, busy;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic [127:0] wdf_din;
  logic [15:0]  wdf_mask_din;
  logic [1:0]   state;

  logic         in_ready2, af_wr_en2, wdf_wr_en2, busy2;
  logic [2:0]   af_cmd_din2;
  logic [30:0]  af_addr_din2;
  logic [127:0] wdf_din2;
  logic [15:0]  wdf_mask_din2;
  logic [1:0]   state2;

  always #5 clk = ~clk;

  gp_write_fifo dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .flush(flush),
    .af_full(af_full), .wdf_full(wdf_full), .af_wr_en(af_wr_en),
    .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .wdf_wr_en(wdf_wr_en),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .busy(busy), .state(state)
  );

  gp_write_fifo #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .flush(flush),
    .af_full(af_full), .wdf_full(wdf_full), .af_wr_en(af_wr_en2),
    .af_cmd_din(af_cmd_din2), .af_addr_din(af_addr_din2), .wdf_wr_en(wdf_wr_en2),
    .wdf_din(wdf_din2), .wdf_mask_din(wdf_mask_din2), .busy(busy2), .state(state2)
  );

  typedef struct { int ed; logic [30:0] addr; logic [2:0] cmd; } af_rec_t;
  typedef struct { int ed; logic [127:0] d; logic [15:0] m; } wdf_rec_t;
  typedef struct { int n; logic fl; logic [15:0] m1; logic [15:0] m2; } vec_t;

  af_rec_t  af_q[$];
  af_rec_t  af2_q[$];
  wdf_rec_t wdf_q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record pushes mid-cycle; they take effect at the next edge (cyc + 1).
  always @(negedge clk) begin
    if (af_wr_en) af_q.push_back('{cyc + 1, af_addr_din, af_cmd_din});
    if (af_wr_en2) af2_q.push_back('{cyc + 1, af_addr_din2, af_cmd_din2});
    if (wdf_wr_en) wdf_q.push_back('{cyc + 1, wdf_din, wdf_mask_din});
    if ((af_wr_en && af_full) || (wdf_wr_en && wdf_full)) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_while_full: af_wr_en=%0b af_full=%0b wdf_wr_en=%0b wdf_full=%0b",
               af_wr_en, af_full, wdf_wr_en, wdf_full);
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (!in_ready) check("push_timeout", {127'd0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_start(input logic [30:0] b);
    start     = 1'b1;
    base_addr = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (busy && t < 100) begin
      step();
      t++;
    end
    if (busy) check("drain_timeout", {127'd0, busy}, 128'd0);
  endtask

  task automatic wait_beat2();
    int t = 0;
    while (state != 2'd2 && t < 50) begin
      step();
      t++;
    end
    if (state != 2'd2) check("beat2_timeout", {126'd0, state}, 128'd2);
  endtask

  // Checks one burst: af entry ai, wdf entries wi/wi+1, words pat+i for i<n.
  task automatic check_burst(input string nm, input int ai, input int wi,
                             input logic [30:0] exp_addr, input logic [31:0] pat,
                             input int n, input logic [15:0] m1, input logic [15:0] m2,
                             input int e0);
    logic [127:0] exp1, exp2, vm1, vm2;
    exp1 = '0; exp2 = '0; vm1 = '0; vm2 = '0;
    for (int i = 0; i < 4; i++) begin
      exp1[32*i +: 32] = pat + 32'(i);
      exp2[32*i +: 32] = pat + 32'(i + 4);
      if (i < n) vm1[32*i +: 32] = '1;
      if (i + 4 < n) vm2[32*i +: 32] = '1;
    end
    if (af_q.size() <= ai || wdf_q.size() <= wi + 1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s missing: af pushes %0d wdf pushes %0d, need %0d and %0d", nm,
               af_q.size(), wdf_q.size(), ai + 1, wi + 2);
      return;
    end
    check({nm, " addr"}, 128'(af_q[ai].addr), 128'(exp_addr));
    check({nm, " cmd"}, 128'(af_q[ai].cmd), 128'd0);
    check({nm, " beat1"}, wdf_q[wi].d & vm1, exp1 & vm1);
    check({nm, " mask1"}, 128'(wdf_q[wi].m), 128'(m1));
    check({nm, " beat2"}, wdf_q[wi + 1].d & vm2, exp2 & vm2);
    check({nm, " mask2"}, 128'(wdf_q[wi + 1].m), 128'(m2));
    if (e0 >= 0) begin
      check({nm, " af_edge"}, 128'(af_q[ai].ed), 128'(e0 + 2));
      check({nm, " b1_edge"}, 128'(wdf_q[wi].ed), 128'(e0 + 2));
      check({nm, " b2_edge"}, 128'(wdf_q[wi + 1].ed), 128'(e0 + 3));
    end
  endtask

  task automatic clear_q();
    af_q.delete();
    af2_q.delete();
    wdf_q.delete();
  endtask

  vec_t tbl[8];

  initial begin
    int e0;
    int cnt;
    int rel;
    logic [31:0] pat;

    tbl[0] = '{8, 1'b0, 16'h0000, 16'h0000};
    tbl[1] = '{3, 1'b1, 16'hF000, 16'hFFFF};
    tbl[2] = '{5, 1'b1, 16'h0000, 16'hFFF0};
    tbl[3] = '{1, 1'b1, 16'hFFF0, 16'hFFFF};
    tbl[4] = '{7, 1'b1, 16'h0000, 16'hF000};
    tbl[5] = '{8, 1'b0, 16'h0000, 16'h0000};
    tbl[6] = '{6, 1'b1, 16'h0000, 16'hFF00};
    tbl[7] = '{4, 1'b1, 16'h0000, 16'hFFFF};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; flush = 1'b0;
    af_full = 1'b0; wdf_full = 1'b0; base_addr = '0; in_data = '0;
    repeat (3) step();
    check("rst state", 128'(state), 128'd0);
    check("rst busy", 128'(busy), 128'd0);
    check("rst in_ready", 128'(in_ready), 128'd1);
    check("rst af_wr_en", 128'(af_wr_en), 128'd0);
    check("rst wdf_wr_en", 128'(wdf_wr_en), 128'd0);
    check("rst af_cmd", 128'(af_cmd_din), 128'd0);
    rst = 1'b0;
    step();

    // Table: block sizes, full blocks and flushed partial blocks.
    do_start(31'h100);
    cnt = 0;
    for (int e = 0; e < 8; e++) begin
      clear_q();
      pat = 32'hA000_0000 + 32'(e << 8);
      for (int i = 0; i < tbl[e].n; i++) push(pat + 32'(i));
      if (tbl[e].fl) do_flush();
      e0 = cyc;
      wait_drain();
      check($sformatf("tbl%0d af_count", e), 128'(af_q.size()), 128'd1);
      check_burst($sformatf("tbl%0d", e), 0, 0, 31'(32'h100 + 4 * cnt), pat, tbl[e].n,
                  tbl[e].m1, tbl[e].m2, e0);
      cnt++;
    end

    // af_full held while both blocks fill.
    clear_q();
    do_start(31'h100);
    cnt = 0;
    af_full = 1'b1;
    for (int i = 0; i < 16; i++) push(32'h200 + 32'(i));
    check("bp in_ready_low", 128'(in_ready), 128'd0);
    repeat (3) step();
    check("bp no_af", 128'(af_q.size()), 128'd0);
    check("bp no_wdf", 128'(wdf_q.size()), 128'd0);
    check("bp state_cmd", 128'(state), 128'd1);
    af_full = 1'b0;
    step();
    check("bp in_ready_after_b1", 128'(in_ready), 128'd0);
    step();
    check("bp in_ready_after_b2", 128'(in_ready), 128'd1);
    wait_drain();
    check("bp af_count", 128'(af_q.size()), 128'd2);
    check_burst("bp0", 0, 0, 31'h100, 32'h200, 8, 16'h0, 16'h0, -1);
    check_burst("bp1", 1, 2, 31'h104, 32'h208, 8, 16'h0, 16'h0, -1);
    cnt = 2;

    // Word accepted together with flush completes the block; later flush is a no-op.
    clear_q();
    for (int i = 0; i < 7; i++) push(32'hC00 + 32'(i));
    in_valid = 1'b1; in_data = 32'hC07; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    e0 = cyc;
    wait_drain();
    check_burst("flacc", 0, 0, 31'(32'h100 + 4 * cnt), 32'hC00, 8, 16'h0, 16'h0, e0);
    cnt++;
    clear_q();
    do_flush();
    repeat (4) step();
    check("empty_flush af", 128'(af_q.size()), 128'd0);
    check("empty_flush busy", 128'(busy), 128'd0);

    // wdf_full held for 5 cycles in BEAT2.
    clear_q();
    for (int i = 0; i < 8; i++) push(32'hD00 + 32'(i));
    wait_beat2();
    wdf_full = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("wstall wdf_wr_en", 128'(wdf_wr_en), 128'd0);
      check("wstall wdf_din", wdf_din, {32'hD07, 32'hD06, 32'hD05, 32'hD04});
      step();
    end
    wdf_full = 1'b0;
    rel = cyc;
    wait_drain();
    check_burst("wstall", 0, 0, 31'(32'h100 + 4 * cnt), 32'hD00, 8, 16'h0, 16'h0, -1);
    if (wdf_q.size() > 1) check("wstall b2_edge", 128'(wdf_q[1].ed), 128'(rel + 1));
    cnt++;

    // start while busy is ignored.
    clear_q();
    for (int i = 0; i < 8; i++) push(32'hE00 + 32'(i));
    check("sbusy busy", 128'(busy), 128'd1);
    do_start(31'h200);
    wait_drain();
    check_burst("sbusy", 0, 0, 31'(32'h100 + 4 * cnt), 32'hE00, 8, 16'h0, 16'h0, -1);
    cnt++;

    // Reset during BEAT2 aborts the burst.
    clear_q();
    for (int i = 0; i < 8; i++) push(32'hF00 + 32'(i));
    wait_beat2();
    wdf_full = 1'b1;
    step();
    rst = 1'b1;
    step();
    wdf_full = 1'b0;
    #1;
    check("rstb2 af_wr_en", 128'(af_wr_en), 128'd0);
    check("rstb2 wdf_wr_en", 128'(wdf_wr_en), 128'd0);
    check("rstb2 busy", 128'(busy), 128'd0);
    check("rstb2 in_ready", 128'(in_ready), 128'd1);
    check("rstb2 state", 128'(state), 128'd0);
    rst = 1'b0;
    step();

    // Burst counter wrap with CNT_WIDTH=2 (dut2); default instance keeps counting.
    clear_q();
    do_start(31'h40);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) push(32'h1000 + 32'(k * 16 + i));
      wait_drain();
    end
    check("wrap count", 128'(af2_q.size()), 128'd5);
    check("wide count", 128'(af_q.size()), 128'd5);
    for (int k = 0; k < 5; k++) begin
      if (af2_q.size() > k)
        check($sformatf("wrap addr%0d", k), 128'(af2_q[k].addr), 128'(32'h40 + 4 * (k % 4)));
      if (af_q.size() > k)
        check($sformatf("wide addr%0d", k), 128'(af_q[k].addr), 128'(32'h40 + 4 * k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
